// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle HI/LO multiply/divide unit (radix-2 shift-add / restoring divide) with mthi/mtlo writes.
// Optional macro HILO_FWD_EN forwards accepted mthi/mtlo data combinationally onto outHI/outLO.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO,
    output logic             busy,
    output logic             done,
    output logic             divZero
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p, w_mres;
    logic [WIDTH-1:0]     r_m, r_a, r_hi, r_lo;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_q, w_r, w_diff;
    logic [WIDTH:0]       w_sum, w_rs;
    logic                 r_op, r_neg, r_rneg, r_dz, r_done, r_div_zero;
    logic                 w_sa, w_sb, w_ge, w_idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? CALC : IDLE) :
                 (r_state == CALC) ? ((r_cnt == CW'(ITER - 1)) ? FINISH : CALC) : IDLE;
    end

    assign w_idle  = r_state == IDLE;
    assign w_sa    = sign & A[WIDTH-1];
    assign w_sb    = sign & B[WIDTH-1];
    assign w_a_mag = w_sa ? -A : A;
    assign w_b_mag = w_sb ? -B : B;

    // r_p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    assign w_rs   = r_p[2*WIDTH-1:WIDTH-1];
    assign w_ge   = w_rs >= {1'b0, r_m};
    assign w_diff = w_rs[WIDTH-1:0] - r_m;
    assign w_mres = r_neg ? -r_p : r_p;
    assign w_q    = r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_r    = r_rneg ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_m        <= '0;
            r_a        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_op       <= 1'b0;
            r_neg      <= 1'b0;
            r_rneg     <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (r_state == IDLE) begin
            r_done <= 1'b0;
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
            if (start) begin
                r_op       <= op;
                r_m        <= w_b_mag;
                r_p        <= {{WIDTH{1'b0}}, w_a_mag};
                r_a        <= A;
                r_neg      <= w_sa ^ w_sb;
                r_rneg     <= w_sa;
                r_dz       <= op & (B == '0);
                r_div_zero <= 1'b0;
                r_cnt      <= '0;
            end
        end else if (r_state == CALC) begin
            r_p   <= r_op ? {w_ge ? w_diff : w_rs[WIDTH-1:0], r_p[WIDTH-2:0], w_ge}
                          : {w_sum, r_p[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_done     <= 1'b1;
            r_hi       <= r_dz ? r_a : r_op ? w_r : w_mres[2*WIDTH-1:WIDTH];
            r_lo       <= r_dz ? '1  : r_op ? w_q : w_mres[WIDTH-1:0];
            r_div_zero <= r_dz;
        end
    end

`ifdef HILO_FWD_EN
    assign outHI = (w_idle && hi_we) ? wdata : r_hi;
    assign outLO = (w_idle && lo_we) ? wdata : r_lo;
`else
    assign outHI = r_hi;
    assign outLO = r_lo;
`endif
    assign busy    = !w_idle;
    assign done    = r_done;
    assign divZero = r_div_zero;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard bench for hilo_muldiv; a monitor pops expected HI/LO/divZero/latency on each done pulse.
module tb_hilo_muldiv;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0, sign = 1'b0;
    logic [31:0] A = '0, B = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] outHI, outLO;
    logic        busy, done, divZero;
    logic [31:0] cyc = '0;
    logic        prev_done = 1'b0;
    int          checks = 0, failures = 0;
    exp_t        sb[$];
    exp_t        e;

    hilo_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
        .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .outHI(outHI), .outLO(outLO), .busy(busy), .done(done), .divZero(divZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("hi", outHI, e.hi);
                chk("lo", outLO, e.lo);
                chk("divzero", divZero, e.dz);
                chk("latency", cyc, e.cyc);
            end
            chk("done_width", prev_done, 0);
        end
        prev_done = done & !reset;
    end

    task automatic issue(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input bit push);
        @(negedge clk);
        start = 1'b1; op = o; sign = s; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) sb.push_back('{hi: ehi, lo: elo, dz: edz, cyc: cyc + 33});
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        chk("idle_timeout", busy, 0);
    endtask

    task automatic run(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        issue(o, s, a, b, ehi, elo, edz, 1'b1);
        wait_idle();
    endtask

    initial begin
        #1;
        chk("rst_hi", outHI, 0);
        chk("rst_lo", outLO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", divZero, 0);
        @(negedge clk);
        reset = 1'b0;

        run(0, 0, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 0);

        // second start and an mthi while busy must both be dropped
        issue(0, 0, 32'd3, 32'd5, 32'h0, 32'hF, 0, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b1; sign = 1'b0; A = 32'd99; B = 32'd0;
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        chk("busy_hi_stable", outHI, 32'h1);
        chk("busy_lo_stable", outLO, 32'hFFFFFFFE);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("no_queued_start", busy, 0);

        // mthi together with start: write lands now, result overwrites later
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h5555; start = 1'b1; op = 1'b0; sign = 1'b0; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;
        hi_we = 1'b0; start = 1'b0;
        sb.push_back('{hi: 32'h0, lo: 32'h2A, dz: 1'b0, cyc: cyc + 33});
        chk("mthi_with_start_hi", outHI, 32'h5555);
        chk("mthi_with_start_lo", outLO, 32'hF);
        chk("mthi_with_start_busy", busy, 1);
        wait_idle();

        run(0, 1, -32'sd4, -32'sd8, 32'h0, 32'd32, 0);
        run(0, 1, -32'sd4, 32'd8, 32'hFFFFFFFF, 32'hFFFFFFE0, 0);
        run(0, 0, 32'h10000, 32'h10000, 32'h1, 32'h0, 0);
        run(1, 1, 32'd32, -32'sd10, 32'd2, 32'hFFFFFFFD, 0);
        run(1, 1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run(1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run(1, 0, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1);
        repeat (2) @(negedge clk);
        chk("dz_sticky", divZero, 1);
        run(1, 1, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
        issue(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 1'b1);
        chk("dz_cleared_on_start", divZero, 0);
        wait_idle();

        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi_both", outHI, 32'hCAFE);
        chk("mtlo_both", outLO, 32'hCAFE);

        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hABCD;
        #1;
`ifdef HILO_FWD_EN
        chk("mtlo_same_cycle", outLO, 32'hABCD);
`else
        chk("mtlo_same_cycle", outLO, 32'hCAFE);
`endif
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo_after_edge", outLO, 32'hABCD);
        chk("mtlo_hi_untouched", outHI, 32'hCAFE);

        // reset mid-operation abandons the result
        issue(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_hi", outHI, 0);
        chk("midrst_lo", outLO, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        run(0, 0, 32'd9, 32'd9, 32'h0, 32'd81, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand, HI and LO width; only 32 is supported.
REQ-002 SHALL have parameter ITER, default 32, meaning the number of radix-2 iteration cycles per operation; it SHALL equal WIDTH.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, the operation request, sampled in IDLE only.
REQ-006 SHALL have port op, input, 1 bit, selecting the operation: 0 = multiply, 1 = divide.
REQ-007 SHALL have port sign, input, 1 bit, selecting the operand interpretation: 1 = two's complement, 0 = unsigned.
REQ-008 SHALL have port A, input, 32 bits, the multiplicand or dividend.
REQ-009 SHALL have port B, input, 32 bits, the multiplier or divisor.
REQ-010 SHALL have port hi_we, input, 1 bit, the mthi write strobe.
REQ-011 SHALL have port lo_we, input, 1 bit, the mtlo write strobe.
REQ-012 SHALL have port wdata, input, 32 bits, the data for mthi/mtlo.
REQ-013 SHALL have port outHI, output, 32 bits, the HI register.
REQ-014 SHALL have port outLO, output, 32 bits, the LO register.
REQ-015 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-016 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-017 SHALL have port divZero, output, 1 bit, a sticky flag set by a divide with B=0 and cleared by the next accepted start.

Function
REQ-018 SHALL implement the states IDLE, CALC and FINISH.
- IDLE -> CALC on start=1.
- CALC -> FINISH after ITER iteration cycles.
- FINISH -> IDLE unconditionally.
REQ-019 SHALL capture A, B, op and sign in IDLE on the start edge (edge k).
- busy=1 from edge k to edge k+33.
- outHI/outLO update at edge k+33.
- done=1 for exactly the cycle following edge k+33.
- The total latency is therefore 33 cycles.
REQ-020 SHALL ignore start while busy=1; no queueing takes place.
REQ-021 SHALL multiply with a shift-add over the operand magnitudes.
- Result is 64 bits: HI = bits 63:32, LO = bits 31:0.
- When sign=1 and exactly one operand is negative, the 64-bit result is negated.
REQ-022 SHALL divide with a restoring shift-subtract over the operand magnitudes.
- LO = quotient, HI = remainder.
- When sign=1: quotient is negative iff the operand signs differ; remainder takes the sign of A.
REQ-023 SHALL handle divide by zero (B=0) as follows: HI=A, LO=32'hFFFFFFFF, divZero=1, with the full 33-cycle latency.
REQ-024 SHALL produce, for a signed divide of 32'h80000000 by 32'hFFFFFFFF, LO=32'h80000000 and HI=0.
REQ-025 SHALL write wdata to HI on hi_we and/or to LO on lo_we at the next edge when busy=0.
- Both strobes may be asserted in the same cycle.
- While busy=1 the strobes SHALL be ignored.
REQ-026 SHALL, when hi_we and start are asserted together in IDLE, perform the write and accept the start; the completed result later overwrites HI.
REQ-027 SHALL leave outHI/outLO stable throughout CALC and change them only in FINISH or on an mthi/mtlo write.

Reset
REQ-028 SHALL, on reset=1 and at any time including mid-operation:
- force the state to IDLE;
- clear outHI, outLO, busy, done and divZero to 0;
- abandon any in-flight operation without updating HI/LO.
REQ-029 SHALL leave the first start accepted after reset deassertion with the full 33-cycle latency.

Configuration
REQ-030 SHALL support the macro HILO_FWD_EN.
- Defined: outHI/outLO combinationally reflect wdata in the same cycle that hi_we/lo_we are accepted.
- Undefined: the written value appears only after the clock edge.
- All other behaviour is identical with or without the macro.

Verification
REQ-031 SHALL check: unsigned multiply A=32'hFFFFFFFF, B=2, sign=0 -> after 33 cycles HI=1, LO=32'hFFFFFFFE, done pulses once.
REQ-032 SHALL check: signed multiply A=-4, B=-8, sign=1 -> HI=0, LO=32; signed multiply A=-4, B=8 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFE0.
REQ-033 SHALL check: signed divide A=32, B=-10 -> LO=32'hFFFFFFFD, HI=2; divide A=7, B=0 -> HI=7, LO=32'hFFFFFFFF, divZero=1.
REQ-034 SHALL check: start asserted at cycle 5 of CALC -> ignored, first result unchanged; hi_we with wdata=32'h1234 while busy -> HI unaffected.
REQ-035 SHALL check: reset pulsed at cycle 10 of CALC -> HI=LO=0, busy=0 immediately; a fresh start completes in 33 cycles.
REQ-036 SHALL check: lo_we with wdata=32'hABCD in IDLE -> with HILO_FWD_EN outLO=32'hABCD in the same cycle, without it outLO=32'hABCD after the next edge.
